// File: rtl/pio_out_bank.sv
// Multi-channel output PIO bank with per-channel shadow registers.
// Shadow values reach out_port either immediately (AUTO) or all at once
// through a delayed commit countdown.
module pio_out_bank #(
    parameter int                WIDTH       = 4,
    parameter int                CHANNELS    = 4,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int                CNT_W       = 16,
    parameter int                ADDR_W      = $clog2(4*CHANNELS) + 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDR_W-1:0]            address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic [CHANNELS*WIDTH-1:0]    out_port,
    output logic                         commit_pulse
);

    // state    | meaning
    // ST_IDLE  | no commit pending, busy reads 0
    // ST_ARMED | countdown running; applies shadow->out when cnt reaches 0
    typedef enum logic {ST_IDLE, ST_ARMED} state_t;

    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(4*CHANNELS);
    localparam logic [ADDR_W-1:0] COMMIT_ADDR = ADDR_W'(4*CHANNELS + 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 auto_mode;
    logic [WIDTH-1:0]     shadow [CHANNELS];
    logic [WIDTH-1:0]     out_q  [CHANNELS];
    logic [WIDTH-1:0]     sh_nxt [CHANNELS];
    logic [CHANNELS-1:0]  sh_wr;

    logic                 wr_en;
    logic                 commit_wr;
    logic                 ctrl_wr;
    logic                 busy;
    logic                 apply;
    logic [WIDTH-1:0]     wd;

    // Upper write-data bits have no destination in a narrow bank.
    logic                 unused_writedata;
    assign unused_writedata = &{1'b0, writedata};

    assign wr_en     = chipselect && !write_n;
    assign commit_wr = wr_en && (address == COMMIT_ADDR);
    assign ctrl_wr   = wr_en && (address == CTRL_ADDR);
    assign wd        = writedata[WIDTH-1:0];
    assign busy      = (state == ST_ARMED);
    // A commit write on the terminal edge restarts the countdown instead of firing.
    assign apply     = busy && (cnt == '0) && !commit_wr;

    // Per-channel shadow write decode: DATA / SET / CLR.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sh_wr[c]  = 1'b0;
            sh_nxt[c] = shadow[c];
            if (wr_en && (address == ADDR_W'(4*c))) begin
                sh_wr[c]  = 1'b1;
                sh_nxt[c] = wd;
            end else if (wr_en && (address == ADDR_W'(4*c + 1))) begin
                sh_wr[c]  = 1'b1;
                sh_nxt[c] = shadow[c] | wd;
            end else if (wr_en && (address == ADDR_W'(4*c + 2))) begin
                sh_wr[c]  = 1'b1;
                sh_nxt[c] = shadow[c] & ~wd;
            end
        end
    end

    // Shadow registers take every decoded channel write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                shadow[c] <= RESET_VALUE;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (sh_wr[c]) begin
                    shadow[c] <= sh_nxt[c];
                end
            end
        end
    end

    // Committed outputs: an AUTO write on a channel beats a simultaneous commit,
    // otherwise commit copies the pre-write shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                out_q[c] <= RESET_VALUE;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (auto_mode && sh_wr[c]) begin
                    out_q[c] <= sh_nxt[c];
                end else if (apply) begin
                    out_q[c] <= shadow[c];
                end
            end
        end
    end

    // AUTO control bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_mode <= 1'b0;
        end else if (ctrl_wr) begin
            auto_mode <= writedata[0];
        end
    end

    // Commit sequencer: down-counter with terminal-count apply and one-cycle strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            commit_pulse <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            if (commit_wr) begin
                state <= ST_ARMED;
                cnt   <= writedata[CNT_W-1:0];
            end else if (state == ST_ARMED) begin
                if (cnt == '0) begin
                    state        <= ST_IDLE;
                    commit_pulse <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    // Zero-wait-state read decode.
    always_comb begin
        readdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (address == ADDR_W'(4*c)) begin
                readdata = 32'(shadow[c]);
            end else if (address == ADDR_W'(4*c + 1)) begin
                readdata = 32'(out_q[c]);
            end
        end
        if (address == CTRL_ADDR) begin
            readdata = {31'b0, auto_mode};
        end else if (address == COMMIT_ADDR) begin
            readdata     = 32'(cnt);
            readdata[31] = busy;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign out_port[g*WIDTH +: WIDTH] = out_q[g];
    end

endmodule

// File: tb/tb_pio_out_bank.sv
// Testbench for pio_out_bank: directed test-plan steps followed by random
// bus traffic checked against an edge-count based reference model.
module tb_pio_out_bank;

    logic        clk;
    logic        reset_n;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] out_port;
    logic        commit_pulse;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [3:0] sh_m  [4];
    logic [3:0] out_m [4];
    logic       auto_m;
    logic       pulse_m;
    logic       pending;
    int         cyc;
    int         due;

    pio_out_bank #(
        .WIDTH(4), .CHANNELS(4), .RESET_VALUE(4'h5), .CNT_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .commit_pulse(commit_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            sh_m[i]  = 4'h5;
            out_m[i] = 4'h5;
        end
        auto_m  = 1'b0;
        pulse_m = 1'b0;
        pending = 1'b0;
        due     = 0;
    endtask

    function automatic logic [15:0] model_out();
        return {out_m[3], out_m[2], out_m[1], out_m[0]};
    endfunction

    function automatic logic [31:0] model_rd(input int a);
        if (a < 16) begin
            if (a % 4 == 0) return 32'(sh_m[a/4]);
            if (a % 4 == 1) return 32'(out_m[a/4]);
            return 32'h0;
        end
        if (a == 16) return {31'b0, auto_m};
        if (a == 17) return pending ? (32'h8000_0000 | 32'(due - cyc - 1)) : 32'h0;
        return 32'h0;
    endfunction

    // One clock edge of the model: commit fires when the edge count reaches the due edge.
    task automatic model_edge(input logic w, input int a, input logic [31:0] d);
        logic [3:0] old_sh [4];
        logic       is_commit;
        cyc++;
        old_sh    = sh_m;
        is_commit = w && (a == 17);
        pulse_m   = pending && (cyc == due) && !is_commit;
        if (w && a < 16) begin
            case (a % 4)
                0: sh_m[a/4] = d[3:0];
                1: sh_m[a/4] = sh_m[a/4] | d[3:0];
                2: sh_m[a/4] = sh_m[a/4] & ~d[3:0];
                default: ;
            endcase
        end
        if (pulse_m) begin
            out_m   = old_sh;
            pending = 1'b0;
        end
        if (w && a < 16 && (a % 4) != 3 && auto_m) out_m[a/4] = sh_m[a/4];
        if (w && a == 16) auto_m = d[0];
        if (is_commit) begin
            pending = 1'b1;
            due     = cyc + int'(d[15:0]) + 1;
        end
    endtask

    // Drive one bus cycle, advance the model, then check outputs just after the edge.
    task automatic tick(input logic w, input int a, input logic [31:0] d);
        chipselect = w;
        write_n    = !w;
        address    = 5'(a);
        writedata  = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("out_port", 32'(out_port), 32'(model_out()));
        check("commit_pulse", 32'(commit_pulse), 32'(pulse_m));
    endtask

    task automatic rd_check(input string tag, input int a);
        address = 5'(a);
        #1;
        check(tag, readdata, model_rd(a));
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        cyc        = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        check("rst_out_port", 32'(out_port), 32'h5555);
        check("rst_pulse", 32'(commit_pulse), 32'h0);
        address = 5'd17; #1; check("rst_commit_rd", readdata, 32'h0);
        address = 5'd16; #1; check("rst_ctrl_rd", readdata, 32'h0);

        // Shadow isolation
        tick(1'b1, 8, 32'hFFFF_FFFA);
        check("shadow_iso_out", 32'(out_port), 32'h5555);
        address = 5'd8; #1; check("data2_rd", readdata, 32'hA);
        tick(1'b1, 9, 32'h1);
        tick(1'b1, 10, 32'h8);
        address = 5'd8; #1; check("data2_setclr", readdata, 32'h3);
        address = 5'd9; #1; check("set2_rd_committed", readdata, 32'h5);

        // Delayed commit of 3
        tick(1'b1, 17, 32'h3);
        address = 5'd17; #1; check("cnt3", readdata, 32'h8000_0003);
        tick(1'b0, 0, 0);
        address = 5'd17; #1; check("cnt2", readdata, 32'h8000_0002);
        tick(1'b0, 0, 0);
        address = 5'd17; #1; check("cnt1", readdata, 32'h8000_0001);
        tick(1'b0, 0, 0);
        address = 5'd17; #1; check("cnt0", readdata, 32'h8000_0000);
        check("pre_apply_out", 32'(out_port), 32'h5555);
        tick(1'b0, 0, 0);
        check("apply_out", 32'(out_port), 32'h5355);
        check("apply_pulse", 32'(commit_pulse), 32'h1);
        tick(1'b0, 0, 0);
        check("pulse_one_cycle", 32'(commit_pulse), 32'h0);
        address = 5'd17; #1; check("idle_after", readdata, 32'h0);

        // Restart and collision
        tick(1'b1, 0, 32'h9);
        tick(1'b1, 17, 32'h5);
        tick(1'b0, 0, 0);
        tick(1'b1, 17, 32'h0);
        check("restart_no_apply", 32'(commit_pulse), 32'h0);
        tick(1'b1, 4, 32'hC);
        check("restart_pulse", 32'(commit_pulse), 32'h1);
        check("collision_out", 32'(out_port), 32'h5359);
        address = 5'd4; #1; check("collision_shadow", readdata, 32'hC);

        // AUTO mode
        tick(1'b1, 16, 32'h1);
        address = 5'd16; #1; check("ctrl_rd", readdata, 32'h1);
        tick(1'b1, 0, 32'hF);
        check("auto_out", 32'(out_port), 32'h535F);
        check("auto_no_pulse", 32'(commit_pulse), 32'h0);
        tick(1'b1, 16, 32'h0);

        // Reset mid-countdown
        tick(1'b1, 17, 32'd10);
        repeat (3) tick(1'b0, 0, 0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_out", 32'(out_port), 32'h5555);
        @(posedge clk);
        #1 reset_n = 1'b1;
        check("midrst_pulse", 32'(commit_pulse), 32'h0);
        address = 5'd17; #1; check("midrst_busy", readdata, 32'h0);
        repeat (12) tick(1'b0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int          r;
            int          a;
            logic        w;
            logic [31:0] d;
            r = $urandom_range(0, 9);
            w = ($urandom_range(0, 3) != 0);
            d = $urandom;
            if (r < 6) begin
                a = $urandom_range(0, 15);
            end else if (r == 6) begin
                a = 16;
            end else if (r == 7) begin
                a = 17;
                d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
            end else if (r == 8) begin
                a = $urandom_range(18, 31);
            end else begin
                a = 0;
                w = 1'b0;
            end
            tick(w, a, d);
            rd_check("rand_rd", $urandom_range(0, 31));
            rd_check("rand_commit_rd", 17);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
